// File: rtl/alu_seq_flags.sv
// N-bit sequential ALU: registered result and NZCV flags, valid/ready handshake on both sides,
// and an LSB-first shift-add multiplier that takes N cycles.
module alu_seq_flags #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    input  logic         set_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    localparam int unsigned CntW = $clog2(N);
    localparam logic [CntW-1:0] LastIter = CntW'(N - 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpAdc = 3'b100;
    localparam logic [2:0] OpSbc = 3'b101;
    localparam logic [2:0] OpXor = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    result_q, result_d;
    logic [3:0]      flags_q, flags_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sf_q, sf_d;

    // Single-cycle datapath, evaluated on the live inputs at accept
    logic [N-1:0] op_b;
    logic         cin;
    logic [N:0]   sum;
    logic         is_arith;
    logic [N-1:0] alu_res;
    logic         alu_c;
    logic         alu_v;

    always_comb begin
        op_b     = b;
        cin      = 1'b0;
        is_arith = 1'b0;
        case (op)
            OpAdd: begin
                is_arith = 1'b1;
            end
            OpSub: begin
                op_b     = ~b;
                cin      = 1'b1;
                is_arith = 1'b1;
            end
            OpAdc: begin
                cin      = flags_q[1];
                is_arith = 1'b1;
            end
            OpSbc: begin
                op_b     = ~b;
                cin      = flags_q[1];
                is_arith = 1'b1;
            end
            default: ;
        endcase

        sum   = {1'b0, a} + {1'b0, op_b} + {{N{1'b0}}, cin};
        alu_c = sum[N];
        alu_v = (a[N-1] == op_b[N-1]) && (sum[N-1] != a[N-1]);

        case (op)
            OpAnd:   alu_res = a & b;
            OpOr:    alu_res = a | b;
            OpXor:   alu_res = a ^ b;
            default: alu_res = sum[N-1:0];
        endcase
    end

    logic [N-1:0] mul_acc_next;

    always_comb begin
        mul_acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sf_d     = sf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (op == OpMul) begin
                        state_d  = StMul;
                        acc_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        cnt_d    = '0;
                        sf_d     = set_flags;
                    end else begin
                        state_d  = StDone;
                        result_d = alu_res;
                        if (set_flags) begin
                            flags_d[3] = alu_res[N-1];
                            flags_d[2] = (alu_res == '0);
                            if (is_arith) begin
                                flags_d[1] = alu_c;
                                flags_d[0] = alu_v;
                            end
                        end
                    end
                end
            end
            StMul: begin
                acc_d    = mul_acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    // Last partial product: publish result; C and V are left alone
                    state_d  = StDone;
                    result_d = mul_acc_next;
                    cnt_d    = '0;
                    if (sf_q) begin
                        flags_d[3] = mul_acc_next[N-1];
                        flags_d[2] = (mul_acc_next == '0);
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            flags_q  <= 4'b0000;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sf_q     <= sf_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !reset;
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_flags.sv
// Directed bench for alu_seq_flags: a chained vector table (flags carry between rows),
// then backpressure, reset mid-multiply and a 16-bit multiply smoke test.
module tb_alu_seq_flags;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       sf;
        logic [7:0] exp_res;
        logic [3:0] exp_flags;
    } vec_t;

    localparam int NV = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, set_flags, out_valid, out_ready;
    logic [7:0] a, b, result;
    logic [2:0] op;
    logic [3:0] flags;

    logic        in_valid16, in_ready16, set_flags16, out_valid16, out_ready16;
    logic [15:0] a16, b16, result16;
    logic [2:0]  op16;
    logic [3:0]  flags16;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs [NV];

    alu_seq_flags #(.N(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .set_flags (set_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    alu_seq_flags #(.N(16)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .op        (op16),
        .set_flags (set_flags16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .result    (result16),
        .flags     (flags16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one op, wait for the result, record it, then complete the handshake.
    // lat counts clock edges from the accept edge up to the edge that raised out_valid.
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic sf, output logic [7:0] res, output logic [3:0] fl,
                          output int lat, output logic busy_ok);
        int guard;
        guard   = 0;
        busy_ok = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        op = o; a = x; b = y; set_flags = sf; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs so a design that fails to latch operands is exposed
        in_valid = 1'b0; a = ~x; b = ~y; op = 3'b010; set_flags = ~sf;
        lat = 1;
        while (!out_valid && lat < 50) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        fl  = flags;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] res;
        logic [3:0] fl;
        int         lat;
        logic       busy_ok;
        logic       seen;
        int         guard;

        //             op      a      b    sf   result  NZCV
        vecs[0]  = '{3'b000, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b1001};
        vecs[1]  = '{3'b001, 8'h05, 8'h05, 1'b1, 8'h00, 4'b0110};
        vecs[2]  = '{3'b001, 8'h03, 8'h05, 1'b1, 8'hFE, 4'b1000};
        vecs[3]  = '{3'b000, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b0110};
        vecs[4]  = '{3'b100, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000};
        vecs[5]  = '{3'b101, 8'h10, 8'h20, 1'b1, 8'hEF, 4'b1000};
        vecs[6]  = '{3'b101, 8'h20, 8'h10, 1'b1, 8'h0F, 4'b0010};
        vecs[7]  = '{3'b110, 8'hAA, 8'h55, 1'b1, 8'hFF, 4'b1010};
        vecs[8]  = '{3'b011, 8'h00, 8'h00, 1'b1, 8'h00, 4'b0110};
        vecs[9]  = '{3'b000, 8'h80, 8'h80, 1'b1, 8'h00, 4'b0111};
        vecs[10] = '{3'b010, 8'h0F, 8'hF0, 1'b0, 8'h00, 4'b0111};
        vecs[11] = '{3'b111, 8'h0C, 8'h0B, 1'b1, 8'h84, 4'b1011};
        vecs[12] = '{3'b100, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b1001};
        vecs[13] = '{3'b111, 8'hFF, 8'hFF, 1'b0, 8'h01, 4'b1001};
        vecs[14] = '{3'b001, 8'h00, 8'h01, 1'b1, 8'hFF, 4'b1000};
        vecs[15] = '{3'b111, 8'h10, 8'h10, 1'b1, 8'h00, 4'b0100};

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0; set_flags = 1'b0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;
        set_flags16 = 1'b0;

        // Reset state, with a request presented that must be ignored
        repeat (2) @(posedge clk);
        in_valid = 1'b1; op = 3'b000; a = 8'h11; b = 8'h22; set_flags = 1'b1;
        @(posedge clk); #1;
        check("reset in_ready", in_ready, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset result", result, 8'h00);
        check("reset flags", flags, 4'b0000);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("post-reset in_ready", in_ready, 1'b1);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf, res, fl, lat, busy_ok);
            check($sformatf("v%0d result", i), res, vecs[i].exp_res);
            check($sformatf("v%0d flags", i), fl, vecs[i].exp_flags);
            check($sformatf("v%0d latency", i), lat, (vecs[i].op == 3'b111) ? 9 : 1);
            check($sformatf("v%0d in_ready low while busy", i), busy_ok, 1'b1);
        end

        // Backpressure: DONE held for 3 cycles, a competing request must not be taken
        op = 3'b000; a = 8'h01; b = 8'h01; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 3'b000; a = 8'hFF; b = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d out_valid", k), out_valid, 1'b1);
            check($sformatf("bp%0d in_ready", k), in_ready, 1'b0);
            check($sformatf("bp%0d result", k), result, 8'h02);
            check($sformatf("bp%0d flags", k), flags, 4'b0000);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release out_valid", out_valid, 1'b0);
        check("bp release in_ready", in_ready, 1'b1);
        check("bp release result", result, 8'h02);

        // Reset during the 4th multiply cycle discards the op and clears flags
        run_op(3'b000, 8'h80, 8'h80, 1'b1, res, fl, lat, busy_ok);
        check("pre-mul flags", fl, 4'b0111);
        op = 3'b111; a = 8'h0C; b = 8'h0B; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid-mul in_ready", in_ready, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mul reset out_valid", out_valid, 1'b0);
        check("mul reset flags", flags, 4'b0000);
        check("mul reset result", result, 8'h00);
        check("mul reset in_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("mul reset in_ready after", in_ready, 1'b1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("mul reset op discarded", seen, 1'b0);

        // 16-bit multiply smoke test
        guard = 0;
        while (!in_ready16 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        op16 = 3'b111; a16 = 16'h00FF; b16 = 16'h0101; set_flags16 = 1'b1; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0;
        lat = 1;
        while (!out_valid16 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n16 latency", lat, 17);
        check("n16 result", result16, 16'hFFFF);
        check("n16 flags", flags16, 4'b1000);
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        check("n16 release out_valid", out_valid16, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
